// File: rtl/sys_types.sv
// Shared types for the convolution datapath: scalar aliases, tile-scheduler
// state encoding and default systolic-array geometry.
package sys_types;

    typedef logic signed [7:0]  int8_t;
    typedef logic signed [31:0] int32_t;

    localparam int unsigned DEF_SA_N   = 4;
    localparam int unsigned DEF_MASK_W = DEF_SA_N * DEF_SA_N;

    typedef enum logic [2:0] {
        IDLE,
        LAYER_INIT,
        BIAS,
        ISSUE,
        WAIT,
        ADVANCE,
        LAYER_END,
        FINISH
    } sched_state_t;

endpackage

// File: rtl/conv_tile_scheduler_if.sv
// Tile offer/acknowledge channel between the tile scheduler (master) and the
// systolic-array controller (slave).
interface conv_tile_scheduler_if
    import sys_types::*;
#(
    parameter int unsigned MAX_N = 512,
    parameter int unsigned SA_N  = DEF_SA_N
);
    localparam int unsigned P_W = $clog2(MAX_N + 1);

    logic                   tile_valid;
    logic                   tile_ready;
    logic                   tile_done;
    logic [P_W-1:0]         pos_row;
    logic [P_W-1:0]         pos_col;
    logic [SA_N*SA_N-1:0]   pe_mask;

    modport master (
        output tile_valid, pos_row, pos_col, pe_mask,
        input  tile_ready, tile_done
    );

    modport slave (
        input  tile_valid, pos_row, pos_col, pe_mask,
        output tile_ready, tile_done
    );

endinterface

// File: rtl/tile_mask_gen.sv
// Marks which PEs of an SA_N x SA_N tile fall inside the output feature map.
module tile_mask_gen
    import sys_types::*;
#(
    parameter int unsigned MAX_N = 512,
    parameter int unsigned SA_N  = DEF_SA_N
) (
    input  logic [$clog2(MAX_N+1)-1:0] pos_row,
    input  logic [$clog2(MAX_N+1)-1:0] pos_col,
    input  logic [$clog2(MAX_N+1)-1:0] out_h,
    input  logic [$clog2(MAX_N+1)-1:0] out_w,
    output logic [SA_N*SA_N-1:0]       pe_mask
);

    // One extra bit so base + offset near MAX_N cannot wrap.
    localparam int unsigned E_W = $clog2(MAX_N + 1) + 1;

    for (genvar r = 0; r < SA_N; r++) begin : g_row
        for (genvar c = 0; c < SA_N; c++) begin : g_col
            assign pe_mask[r*SA_N+c] =
                ((E_W'(pos_row) + E_W'(r)) < E_W'(out_h)) &&
                ((E_W'(pos_col) + E_W'(c)) < E_W'(out_w));
        end
    end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Walks layers, output channels and SA_N-stepped tiles of each output map,
// offering one tile at a time to the systolic-array controller.
module conv_tile_scheduler
    import sys_types::*;
#(
    parameter int unsigned MAX_N      = 512,
    parameter int unsigned SA_N       = DEF_SA_N,
    parameter int unsigned MAX_NUM_CH = 64,
    parameter int unsigned NUM_LAYERS = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              stall,
    input  logic [$clog2(NUM_LAYERS+1)-1:0]   cfg_num_layers,
    input  logic [$clog2(MAX_N+1)-1:0]        cfg_out_h,
    input  logic [$clog2(MAX_N+1)-1:0]        cfg_out_w,
    input  logic [$clog2(MAX_NUM_CH+1)-1:0]   cfg_num_filters,
    conv_tile_scheduler_if.master             tile,
    output logic                              load_bias,
    output logic [$clog2(NUM_LAYERS)-1:0]     layer_idx,
    output logic [$clog2(MAX_NUM_CH)-1:0]     chnnl_idx,
    output logic                              ram_sel,
    output logic                              busy,
    output logic                              layer_done,
    output logic                              done
);

    localparam int unsigned P_W  = $clog2(MAX_N + 1);
    localparam int unsigned E_W  = P_W + 1;
    localparam int unsigned NL_W = $clog2(NUM_LAYERS + 1);
    localparam int unsigned LC_W = NL_W + 1;
    localparam int unsigned LI_W = $clog2(NUM_LAYERS);
    localparam int unsigned NF_W = $clog2(MAX_NUM_CH + 1);
    localparam int unsigned CI_W = $clog2(MAX_NUM_CH);

    sched_state_t    state_q, state_d;
    logic [NL_W-1:0] num_layers_q, num_layers_d;
    logic [LI_W-1:0] layer_q, layer_d;
    logic [P_W-1:0]  out_h_q, out_h_d, out_w_q, out_w_d;
    logic [P_W-1:0]  row_q, row_d, col_q, col_d;
    logic [NF_W-1:0] nf_q, nf_d, ch_q, ch_d;
    logic            pend_q, pend_d;

    logic [E_W-1:0]  col_step, row_step;
    logic [NF_W-1:0] ch_step;
    logic            last_layer, cfg_zero;

    assign col_step   = E_W'(col_q) + E_W'(SA_N);
    assign row_step   = E_W'(row_q) + E_W'(SA_N);
    assign ch_step    = ch_q + NF_W'(1);
    assign last_layer = (LC_W'(layer_q) + LC_W'(1)) == LC_W'(num_layers_q);
    assign cfg_zero   = (cfg_out_h == '0) || (cfg_out_w == '0) || (cfg_num_filters == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_layers_q <= '0;
            layer_q      <= '0;
            out_h_q      <= '0;
            out_w_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            nf_q         <= '0;
            ch_q         <= '0;
            pend_q       <= 1'b0;
        end else begin
            num_layers_q <= num_layers_d;
            layer_q      <= layer_d;
            out_h_q      <= out_h_d;
            out_w_q      <= out_w_d;
            row_q        <= row_d;
            col_q        <= col_d;
            nf_q         <= nf_d;
            ch_q         <= ch_d;
            pend_q       <= pend_d;
        end
    end

    // Next-state and counter update; everything holds while stalled except the
    // tile_done memory, which catches a completion that arrives mid-stall.
    always_comb begin
        state_d      = state_q;
        num_layers_d = num_layers_q;
        layer_d      = layer_q;
        out_h_d      = out_h_q;
        out_w_d      = out_w_q;
        row_d        = row_q;
        col_d        = col_q;
        nf_d         = nf_q;
        ch_d         = ch_q;
        pend_d       = pend_q;

        if (stall) begin
            if (state_q == WAIT && tile.tile_done) pend_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_layers_d = cfg_num_layers;
                        layer_d      = '0;
                        state_d      = (cfg_num_layers == '0) ? FINISH : LAYER_INIT;
                    end
                end
                LAYER_INIT: begin
                    out_h_d = cfg_out_h;
                    out_w_d = cfg_out_w;
                    nf_d    = cfg_num_filters;
                    row_d   = '0;
                    col_d   = '0;
                    ch_d    = '0;
                    state_d = cfg_zero ? LAYER_END : BIAS;
                end
                BIAS: state_d = ISSUE;
                ISSUE: begin
                    if (tile.tile_ready) begin
                        pend_d  = 1'b0;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (tile.tile_done || pend_q) begin
                        pend_d  = 1'b0;
                        state_d = ADVANCE;
                    end
                end
                ADVANCE: begin
                    state_d = BIAS;
                    if (col_step >= E_W'(out_w_q)) begin
                        col_d = '0;
                        if (row_step >= E_W'(out_h_q)) begin
                            row_d = '0;
                            ch_d  = ch_step;
                            if (ch_step == nf_q) state_d = LAYER_END;
                        end else begin
                            row_d = P_W'(row_step);
                        end
                    end else begin
                        col_d = P_W'(col_step);
                    end
                end
                LAYER_END: begin
                    if (last_layer) begin
                        state_d = FINISH;
                    end else begin
                        layer_d = layer_q + LI_W'(1);
                        state_d = LAYER_INIT;
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    tile_mask_gen #(
        .MAX_N (MAX_N),
        .SA_N  (SA_N)
    ) u_mask (
        .pos_row (row_q),
        .pos_col (col_q),
        .out_h   (out_h_q),
        .out_w   (out_w_q),
        .pe_mask (tile.pe_mask)
    );

    // Pulses are suppressed while stalled; the state holds, so they fire on release.
    assign tile.tile_valid = (state_q == ISSUE);
    assign tile.pos_row    = row_q;
    assign tile.pos_col    = col_q;
    assign load_bias       = (state_q == BIAS) && !stall;
    assign layer_done      = (state_q == LAYER_END) && !stall;
    assign done            = (state_q == FINISH) && !stall;
    assign busy            = (state_q != IDLE);
    assign layer_idx       = layer_q;
    assign chnnl_idx       = ch_q[CI_W-1:0];
    assign ram_sel         = layer_q[0];

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed, table-driven bench for conv_tile_scheduler with hand-computed tiles.
module tb_conv_tile_scheduler;

    localparam int unsigned MAX_N      = 512;
    localparam int unsigned SA_N       = 4;
    localparam int unsigned MAX_NUM_CH = 64;
    localparam int unsigned NUM_LAYERS = 6;
    localparam int unsigned P_W  = $clog2(MAX_N + 1);
    localparam int unsigned NL_W = $clog2(NUM_LAYERS + 1);
    localparam int unsigned NF_W = $clog2(MAX_NUM_CH + 1);
    localparam int unsigned LI_W = $clog2(NUM_LAYERS);
    localparam int unsigned CI_W = $clog2(MAX_NUM_CH);

    typedef struct packed {
        logic [P_W-1:0]       row;
        logic [P_W-1:0]       col;
        logic [SA_N*SA_N-1:0] mask;
        logic [CI_W-1:0]      ch;
        logic                 ram;
    } tile_t;

    typedef struct {
        int          nl;
        int          h0, w0, nf0;
        int          h1, w1, nf1;
        int          exp_tiles, exp_bias, exp_ld;
        logic [15:0] exp_last_mask;
        logic        exp_last_ram;
    } vec_t;

    logic clk = 1'b0;
    logic reset, start, stall;
    logic [NL_W-1:0] cfg_num_layers;
    logic [P_W-1:0]  cfg_out_h, cfg_out_w;
    logic [NF_W-1:0] cfg_num_filters;
    logic            load_bias, ram_sel, busy, layer_done, done;
    logic [LI_W-1:0] layer_idx;
    logic [CI_W-1:0] chnnl_idx;

    int n_cmp = 0;
    int n_err = 0;
    int lh[4], lw[4], lnf[4];
    tile_t tq[$];

    conv_tile_scheduler_if #(.MAX_N(MAX_N), .SA_N(SA_N)) tif ();

    conv_tile_scheduler #(
        .MAX_N(MAX_N), .SA_N(SA_N), .MAX_NUM_CH(MAX_NUM_CH), .NUM_LAYERS(NUM_LAYERS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stall           (stall),
        .cfg_num_layers  (cfg_num_layers),
        .cfg_out_h       (cfg_out_h),
        .cfg_out_w       (cfg_out_w),
        .cfg_num_filters (cfg_num_filters),
        .tile            (tif),
        .load_bias       (load_bias),
        .layer_idx       (layer_idx),
        .chnnl_idx       (chnnl_idx),
        .ram_sel         (ram_sel),
        .busy            (busy),
        .layer_done      (layer_done),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // External per-layer config table, indexed by the scheduler's layer_idx.
    task automatic drive_cfg();
        int i;
        i = int'(layer_idx);
        if (i > 3) i = 3;
        cfg_out_h       = P_W'(lh[i]);
        cfg_out_w       = P_W'(lw[i]);
        cfg_num_filters = NF_W'(lnf[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_cfg();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_cfg_all(input int h, input int w, input int nf);
        for (int l = 0; l < 4; l++) begin
            lh[l] = h; lw[l] = w; lnf[l] = nf;
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, 64'({tif.tile_valid, load_bias, layer_done, done, busy, ram_sel}), 64'd0);
        check({name, "_data"}, 64'({tif.pe_mask, tif.pos_row, tif.pos_col, layer_idx, chnnl_idx}), 64'd0);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        tif.tile_ready = 1'b0; tif.tile_done = 1'b0;
        settle();
        check_zero(name);
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    // Runs one scheduler job with tile_ready high, answering each tile with tile_done
    // three cycles after its handshake; stops on done or when the budget runs out.
    task automatic run_cfg(input int nl, input int budget,
                           output int nbias, output int nld, output int ndone);
        int  dcount;
        bit  fin;
        dcount = 0; fin = 1'b0;
        nbias = 0; nld = 0; ndone = 0;
        tq.delete();
        cfg_num_layers = NL_W'(nl);
        tif.tile_ready = 1'b1;
        start = 1'b1;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            tif.tile_done = (dcount == 1);
            if (dcount > 0) dcount--;
            settle();
            if (load_bias)  nbias++;
            if (layer_done) nld++;
            if (done) begin ndone++; fin = 1'b1; end
            if (tif.tile_valid && tif.tile_ready) begin
                tq.push_back('{tif.pos_row, tif.pos_col, tif.pe_mask, chnnl_idx, ram_sel});
                dcount = 3;
            end
            tick();
            start = 1'b0;
        end
        tif.tile_done  = 1'b0;
        tif.tile_ready = 1'b0;
        settle();
    endtask

    vec_t  vt[7];
    tile_t exp27[4];
    logic [CI_W-1:0] exp28_ch[4];
    logic            exp28_ram[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbias, nld, ndone, hs, found;
        logic [2*P_W+SA_N*SA_N-1:0] snap;

        vt[0] = '{1, 6, 6, 1, 6, 6, 1, 4, 4, 1, 16'h0033, 1'b0};
        vt[1] = '{2, 4, 4, 2, 4, 4, 2, 4, 4, 2, 16'hFFFF, 1'b1};
        vt[2] = '{2, 4, 4, 0, 4, 4, 1, 1, 1, 2, 16'hFFFF, 1'b1};
        vt[3] = '{1, 3, 5, 1, 3, 5, 1, 2, 2, 1, 16'h0111, 1'b0};
        vt[4] = '{0, 4, 4, 1, 4, 4, 1, 0, 0, 0, 16'h0000, 1'b0};
        vt[5] = '{1, 1, 1, 3, 1, 1, 3, 3, 3, 1, 16'h0001, 1'b0};
        vt[6] = '{3, 4, 8, 1, 4, 8, 1, 6, 6, 3, 16'hFFFF, 1'b0};
        exp27[0] = '{10'd0, 10'd0, 16'hFFFF, 6'd0, 1'b0};
        exp27[1] = '{10'd0, 10'd4, 16'h3333, 6'd0, 1'b0};
        exp27[2] = '{10'd4, 10'd0, 16'h00FF, 6'd0, 1'b0};
        exp27[3] = '{10'd4, 10'd4, 16'h0033, 6'd0, 1'b0};
        exp28_ch  = '{6'd0, 6'd1, 6'd0, 6'd1};
        exp28_ram = '{1'b0, 1'b0, 1'b1, 1'b1};

        set_cfg_all(4, 4, 1);
        cfg_num_layers = '0;
        drive_cfg();
        do_reset("reset0");

        // Table-driven whole runs.
        for (int v = 0; v < 7; v++) begin
            lh[0] = vt[v].h0; lw[0] = vt[v].w0; lnf[0] = vt[v].nf0;
            for (int l = 1; l < 4; l++) begin
                lh[l] = vt[v].h1; lw[l] = vt[v].w1; lnf[l] = vt[v].nf1;
            end
            drive_cfg();
            run_cfg(vt[v].nl, 400, nbias, nld, ndone);
            check($sformatf("v%0d_done", v), 64'(ndone), 64'd1);
            check($sformatf("v%0d_tiles", v), 64'(tq.size()), 64'(vt[v].exp_tiles));
            check($sformatf("v%0d_bias", v), 64'(nbias), 64'(vt[v].exp_bias));
            check($sformatf("v%0d_layer_done", v), 64'(nld), 64'(vt[v].exp_ld));
            if (vt[v].exp_tiles > 0 && tq.size() > 0) begin
                check($sformatf("v%0d_last_mask", v), 64'(tq[tq.size()-1].mask), 64'(vt[v].exp_last_mask));
                check($sformatf("v%0d_last_ram", v), 64'(tq[tq.size()-1].ram), 64'(vt[v].exp_last_ram));
            end
            check($sformatf("v%0d_idle", v), 64'(busy), 64'd0);
            if (v == 0) begin
                for (int i = 0; i < 4; i++)
                    check($sformatf("t6x6_tile%0d", i), (i < tq.size()) ? 64'(tq[i]) : 64'd0, 64'(exp27[i]));
            end
            if (v == 1) begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("t2l_ch%0d", i), (i < tq.size()) ? 64'(tq[i].ch) : 64'hDEAD, 64'(exp28_ch[i]));
                    check($sformatf("t2l_ram%0d", i), (i < tq.size()) ? 64'(tq[i].ram) : 64'hDEAD, 64'(exp28_ram[i]));
                end
            end
        end

        // Start latency, ready held low, tile_done outside WAIT ignored.
        set_cfg_all(4, 4, 1);
        cfg_num_layers = NL_W'(1);
        tif.tile_ready = 1'b0;
        start = 1'b1;
        settle();
        check("lat_idle", 64'(busy), 64'd0);
        tick(); start = 1'b0; settle();
        check("lat_init", 64'({busy, load_bias, tif.tile_valid}), 64'b100);
        tick(); tif.tile_done = 1'b1; settle();
        check("lat_bias", 64'({load_bias, tif.tile_valid}), 64'b10);
        tick(); tif.tile_done = 1'b0; settle();
        check("lat_issue", 64'({load_bias, tif.tile_valid}), 64'b01);
        snap = {tif.pos_row, tif.pos_col, tif.pe_mask};
        check("lat_first_tile", 64'(snap), 64'({10'd0, 10'd0, 16'hFFFF}));
        hs = 0;
        for (int i = 0; i < 5; i++) begin
            tif.tile_done = (i == 2);
            settle();
            check($sformatf("hold_valid%0d", i), 64'(tif.tile_valid), 64'd1);
            check($sformatf("hold_stable%0d", i), 64'({tif.pos_row, tif.pos_col, tif.pe_mask}), 64'(snap));
            tick();
        end
        tif.tile_done = 1'b0;
        tif.tile_ready = 1'b1;
        settle();
        if (tif.tile_valid) hs++;
        tick();
        for (int i = 0; i < 3; i++) begin
            tif.tile_done = (i == 2);
            settle();
            if (tif.tile_valid && tif.tile_ready) hs++;
            check($sformatf("wait_hold%0d", i), 64'({busy, tif.tile_valid, layer_done}), 64'b100);
            tick();
        end
        tif.tile_done = 1'b0; tif.tile_ready = 1'b0;
        settle();
        check("hold_handshakes", 64'(hs), 64'd1);
        check("adv_no_ldone", 64'(layer_done), 64'd0);
        tick(); settle();
        check("hold_layer_done", 64'(layer_done), 64'd1);
        tick(); settle();
        check("hold_done", 64'(done), 64'd1);
        tick(); settle();
        check("hold_idle", 64'(busy), 64'd0);

        // Stall in BIAS, in ISSUE, in WAIT with tile_done, and in LAYER_END.
        tif.tile_ready = 1'b1;
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); stall = 1'b1; settle();
        check("stall_bias0", 64'({busy, load_bias}), 64'b10);
        tick(); settle();
        check("stall_bias1", 64'(load_bias), 64'd0);
        tick(); stall = 1'b0; settle();
        check("stall_bias_rel", 64'(load_bias), 64'd1);
        tick(); stall = 1'b1; settle();
        check("stall_issue", 64'(tif.tile_valid), 64'd1);
        tick(); stall = 1'b0; settle();
        check("stall_no_hs", 64'(tif.tile_valid), 64'd1);
        tick(); stall = 1'b1; tif.tile_done = 1'b1; settle();
        check("stall_wait", 64'({busy, tif.tile_valid}), 64'b10);
        tick(); tif.tile_done = 1'b0; settle();
        check("stall_wait_held", 64'({busy, layer_done}), 64'b10);
        tick(); stall = 1'b0; settle();
        check("stall_wait_rel", 64'(busy), 64'd1);
        tick(); settle();
        check("stall_adv", 64'(layer_done), 64'd0);
        tick(); stall = 1'b1; settle();
        check("stall_lend", 64'(layer_done), 64'd0);
        tick(); stall = 1'b0; settle();
        check("stall_lend_rel", 64'(layer_done), 64'd1);
        tick(); settle();
        check("stall_done", 64'(done), 64'd1);
        tick(); settle();
        check("stall_idle", 64'(busy), 64'd0);

        // Reset while waiting on a layer-1 tile, then restart from scratch.
        set_cfg_all(4, 4, 2);
        drive_cfg();
        cfg_num_layers = NL_W'(2);
        tif.tile_ready = 1'b1;
        start = 1'b1;
        found = 0;
        begin
            int dcount;
            dcount = 0;
            for (int cyc = 0; cyc < 200 && found == 0; cyc++) begin
                tif.tile_done = (dcount == 1);
                if (dcount > 0) dcount--;
                settle();
                if (tif.tile_valid && tif.tile_ready) begin
                    dcount = 3;
                    if (layer_idx == LI_W'(1)) found = 1;
                end
                tick();
                start = 1'b0;
            end
        end
        tif.tile_done = 1'b0;
        settle();
        check("rst_reached_l1_wait", 64'({found[0], busy, tif.tile_valid, layer_idx}), 64'({1'b1, 1'b1, 1'b0, 3'd1}));
        reset = 1'b1;
        settle();
        check_zero("rst_wait");
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            if (done) hs++;
        end
        reset = 1'b0;
        settle();
        check("rst_no_done", 64'(hs), 64'd0);
        start = 1'b1;
        found = 0;
        for (int cyc = 0; cyc < 10 && found == 0; cyc++) begin
            settle();
            if (tif.tile_valid) found = 1;
            else begin tick(); start = 1'b0; end
        end
        start = 1'b0;
        check("restart_found", 64'(found), 64'd1);
        check("restart_tile", 64'({layer_idx, ram_sel, tif.pos_row, tif.pos_col, tif.pe_mask}),
              64'({3'd0, 1'b0, 10'd0, 10'd0, 16'hFFFF}));
        reset = 1'b1;
        settle();
        reset = 1'b0;
        tif.tile_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_tile_scheduler.md
CONV_TILE_SCHEDULER -- requirements
Module: conv_tile_scheduler

Interface
REQ-001 SHALL have parameter MAX_N, default 512, maximum output feature-map dimension.
REQ-002 SHALL have parameter SA_N, default 4, systolic array edge and tile step.
REQ-003 SHALL have parameter MAX_NUM_CH, default 64, maximum filters per layer.
REQ-004 SHALL have parameter NUM_LAYERS, default 6, maximum layers per run.
REQ-005 SHALL have ports, in order:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- stall  in  1  freeze scheduler.
- cfg_num_layers  in  $clog2(NUM_LAYERS+1)  layers in run; sampled on start.
- cfg_out_h  in  $clog2(MAX_N+1)  output height of layer layer_idx.
- cfg_out_w  in  $clog2(MAX_N+1)  output width of layer layer_idx.
- cfg_num_filters  in  $clog2(MAX_NUM_CH+1)  filters of layer layer_idx.
- tile_ready  in  1  sta_controller accepts tile.
- tile_done  in  1  one-cycle pulse, accepted tile finished.
- tile_valid  out  1  tile offer.
- pos_row  out  $clog2(MAX_N+1)  tile base row.
- pos_col  out  $clog2(MAX_N+1)  tile base column.
- pe_mask  out  SA_N*SA_N  active PEs; bit r*SA_N+c.
- load_bias  out  1  bias-load pulse.
- layer_idx  out  $clog2(NUM_LAYERS)  current layer; indexes the external config table.
- chnnl_idx  out  $clog2(MAX_NUM_CH)  current output channel.
- ram_sel  out  1  equals layer_idx[0]; 0 = read RAM_A / write RAM_B, 1 = the opposite.
- busy  out  1  high whenever the state is not IDLE.
- layer_done  out  1  one-cycle pulse per finished layer.
- done  out  1  one-cycle pulse at end of run.

Function
REQ-006 SHALL implement states IDLE, LAYER_INIT, BIAS, ISSUE, WAIT, ADVANCE, LAYER_END, FINISH.
REQ-007 IDLE: start=1 SHALL latch cfg_num_layers, clear layer_idx, and go to LAYER_INIT; if the latched count is 0, go to FINISH instead.
REQ-008 LAYER_INIT SHALL latch cfg_out_h, cfg_out_w and cfg_num_filters, and clear row, col and chnnl_idx.
- Any latched value 0: go to LAYER_END.
- Otherwise: go to BIAS.
REQ-009 BIAS SHALL assert load_bias for exactly one cycle, then go to ISSUE.
REQ-010 ISSUE SHALL hold tile_valid=1 with stable pos_row, pos_col and pe_mask until tile_ready=1; on that handshake cycle go to WAIT.
REQ-011 WAIT SHALL ignore tile_ready and go to ADVANCE on tile_done=1; tile_done outside WAIT SHALL be ignored.
REQ-012 ADVANCE SHALL step the tile counters:
- col += SA_N.
- If col >= out_w: col = 0 and row += SA_N.
- If row >= out_h: row = 0 and chnnl_idx += 1.
- If chnnl_idx == num_filters: go to LAYER_END; otherwise go to BIAS.
REQ-013 pe_mask bit r*SA_N+c SHALL be 1 iff pos_row+r < out_h and pos_col+c < out_w; the comparison SHALL be computed at $clog2(MAX_N+1)+1 bits so it never wraps.
REQ-014 LAYER_END SHALL pulse layer_done.
- If layer_idx == num_layers-1: go to FINISH.
- Otherwise: layer_idx += 1, go to LAYER_INIT.
REQ-015 FINISH SHALL pulse done and return to IDLE.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 Latency: with start sampled at edge k, LAYER_INIT is in cycle k+1, load_bias is high in cycle k+2, and tile_valid is first high in cycle k+3.
REQ-018 stall=1 SHALL freeze state, counters and latched config.
- tile_valid, pos_row, pos_col and pe_mask keep their value.
- A tile_ready handshake SHALL NOT complete while stalled.
- load_bias, layer_done and done SHALL be held low while stalled and emitted in the first unstalled cycle.
REQ-019 tile_done arriving during stall in WAIT SHALL be remembered and acted on once stall drops.

Reset
REQ-020 reset SHALL asynchronously force state IDLE.
REQ-021 While reset is asserted, all outputs SHALL be 0, including pe_mask, layer_idx and ram_sel.
REQ-022 Reset mid-tile SHALL abandon the run with no done pulse.
REQ-023 After reset, the next start SHALL begin at layer 0.

Structure
REQ-024 The state enum and SA_N-derived width constants SHALL live in the shared sys_types package alongside int8_t and int32_t.
REQ-025 pe_mask generation SHALL be a combinational sub-module tile_mask_gen with inputs pos_row, pos_col, out_h and out_w.
REQ-026 The block SHALL be implemented in 120-400 lines of RTL.

Verification
REQ-027 Single 6x6 layer, 1 filter, tile_ready tied high: tiles issue at (0,0), (0,4), (4,0), (4,4) with pe_mask 0xFFFF, 0x3333, 0x00FF, 0x0033; then one layer_done and one done.
REQ-028 Two layers of 4x4, 2 filters: four tiles total; ram_sel is 0 then 1; chnnl_idx runs 0,1 within each layer; load_bias pulses 4 times.
REQ-029 tile_ready held low 5 cycles: tile_valid and pe_mask stay stable for those 5 cycles; WAIT is entered exactly once.
REQ-030 stall asserted during BIAS and again during WAIT with tile_done pulsing inside the stall: load_bias is delayed until stall drops, and the tile still completes.
REQ-031 cfg_num_filters=0 on layer 0 of 2: no tile_valid on layer 0; layer_done pulses twice.
REQ-032 reset asserted while in WAIT: outputs go to 0 immediately; a fresh start restarts at layer 0, tile (0,0).
